regf_apb_bridge: RTL and testbench

- Upstream front-end for the generated register files: APB4 slave toward the SoC interconnect, single-cycle strobe memory interface toward a regf's `mem_*` port.
- Checks alignment and byte strobes, issues exactly one `mem_ena` strobe per legal transfer, captures the regf response and completes the APB transfer with registered `prdata` / `pslverr`.
- Sits directly in front of `*_regf` instances; it replaces the tied-off `mem_*` inputs of their wrappers.

---
 rtl/regf_apb_bridge.sv | 119 +++++++++++
 tb/tb_regf_apb_bridge.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regf_apb_bridge.sv
// APB4 slave front-end for a generated register file: checks each transfer,
// issues one mem_ena strobe per legal access and returns the regf response.
module regf_apb_bridge #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 32
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_an_i,
  input  logic                   apb_psel_i,
  input  logic                   apb_penable_i,
  input  logic                   apb_pwrite_i,
  input  logic [ADDRWIDTH+1:0]   apb_paddr_i,
  input  logic [DATAWIDTH-1:0]   apb_pwdata_i,
  input  logic [3:0]             apb_pstrb_i,
  output logic [DATAWIDTH-1:0]   apb_prdata_o,
  output logic                   apb_pready_o,
  output logic                   apb_pslverr_o,
  output logic                   mem_ena_o,
  output logic [ADDRWIDTH-1:0]   mem_addr_o,
  output logic                   mem_wena_o,
  output logic [DATAWIDTH-1:0]   mem_wdata_o,
  input  logic [DATAWIDTH-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic [2:0]             fsm_state_o
);

  // Handshake: a transfer is accepted only in IDLE on a setup phase
  // (psel & !penable); pready is a single-cycle pulse in DONE/ERR, with
  // prdata/pslverr valid only in that cycle. The mem side is a fire-and-forget
  // strobe: mem_ena for one cycle, response valid exactly one cycle later.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic                   wena_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [DATAWIDTH-1:0]   rdata_q;
  logic                   err_q;
  logic                   setup;
  logic                   legal;

  assign setup = apb_psel_i & ~apb_penable_i;
  assign legal = (apb_paddr_i[1:0] == 2'b00) &
                 (~apb_pwrite_i | (apb_pstrb_i == 4'hF));

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wena_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && setup) begin
        addr_q  <= apb_paddr_i[ADDRWIDTH+1:2];
        wena_q  <= apb_pwrite_i;
        wdata_q <= apb_pwdata_i;
      end
      // Writes return zero read data; the regf error is kept for both.
      if (state_q == CAP) begin
        rdata_q <= wena_q ? '0 : mem_rdata_i;
        err_q   <= mem_err_i;
      end
    end
  end

  // Once launched, the access runs to DONE even if psel drops mid-flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = legal ? REQ : ERR;
      REQ:     state_d = CAP;
      CAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ena_o     = 1'b0;
    mem_addr_o    = '0;
    mem_wena_o    = 1'b0;
    mem_wdata_o   = '0;
    apb_pready_o  = 1'b0;
    apb_pslverr_o = 1'b0;
    apb_prdata_o  = '0;
    case (state_q)
      REQ: begin
        mem_ena_o   = 1'b1;
        mem_addr_o  = addr_q;
        mem_wena_o  = wena_q;
        mem_wdata_o = wdata_q;
      end
      DONE: begin
        apb_pready_o  = 1'b1;
        apb_pslverr_o = err_q;
        apb_prdata_o  = rdata_q;
      end
      ERR: begin
        apb_pready_o  = 1'b1;
        apb_pslverr_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_regf_apb_bridge.sv
// Directed bench for regf_apb_bridge: a vector table of single transfers
// plus hand-written reset-abort and psel-drop sequences.
module tb_regf_apb_bridge;

  logic        clk;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [14:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        mem_ena;
  logic [12:0] mem_addr;
  logic        mem_wena;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int ena_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    logic        legal;
    logic [12:0] exp_addr;
    logic [31:0] exp_prdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  regf_apb_bridge dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_pwrite_i  (pwrite),
    .apb_paddr_i   (paddr),
    .apb_pwdata_i  (pwdata),
    .apb_pstrb_i   (pstrb),
    .apb_prdata_o  (prdata),
    .apb_pready_o  (pready),
    .apb_pslverr_o (pslverr),
    .mem_ena_o     (mem_ena),
    .mem_addr_o    (mem_addr),
    .mem_wena_o    (mem_wena),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_err_i     (mem_err),
    .fsm_state_o   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ena) ena_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"},  prdata, 32'h0);
    chk({tag, "_pready"},  {31'h0, pready}, 32'h0);
    chk({tag, "_pslverr"}, {31'h0, pslverr}, 32'h0);
    chk({tag, "_ena"},     {31'h0, mem_ena}, 32'h0);
    chk({tag, "_addr"},    {19'h0, mem_addr}, 32'h0);
    chk({tag, "_wena"},    {31'h0, mem_wena}, 32'h0);
    chk({tag, "_wdata"},   mem_wdata, 32'h0);
    chk({tag, "_state"},   {29'h0, fsm_state}, 32'h0);
  endtask

  task automatic drive_setup(input vec_t v);
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb;
    mem_rdata = 32'hBAD0BAD0; mem_err = 1'b1;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; mem_rdata = 32'hBAD0BAD0; mem_err = 1'b1;
  endtask

  // driver: one complete transfer from setup to the IDLE cycle after pready
  task automatic do_xfer(input vec_t v);
    int c0;
    @(negedge clk);
    drive_setup(v);
    chk("t0_pready", {31'h0, pready}, 32'h0);
    c0 = ena_cnt;
    exp_q.push_back(v.exp_prdata);
    @(negedge clk);
    penable = 1'b1;
    if (v.legal) begin
      chk("t1_ena",    {31'h0, mem_ena}, 32'h1);
      chk("t1_addr",   {19'h0, mem_addr}, {19'h0, v.exp_addr});
      chk("t1_wena",   {31'h0, mem_wena}, {31'h0, v.wr});
      chk("t1_wdata",  mem_wdata, v.wdata);
      chk("t1_pready", {31'h0, pready}, 32'h0);
      @(negedge clk);
      chk("t2_ena",    {31'h0, mem_ena}, 32'h0);
      chk("t2_pready", {31'h0, pready}, 32'h0);
      mem_rdata = v.rdata; mem_err = v.err;
      @(negedge clk);
      chk("t3_pready",  {31'h0, pready}, 32'h1);
      chk("t3_prdata",  prdata, exp_q.pop_front());
      chk("t3_pslverr", {31'h0, pslverr}, {31'h0, v.exp_err});
      chk("t3_ena",     {31'h0, mem_ena}, 32'h0);
    end else begin
      chk("t1_ena",     {31'h0, mem_ena}, 32'h0);
      chk("t1_pready",  {31'h0, pready}, 32'h1);
      chk("t1_pslverr", {31'h0, pslverr}, 32'h1);
      chk("t1_prdata",  prdata, exp_q.pop_front());
    end
    bus_idle();
    @(negedge clk);
    chk("idle_pready", {31'h0, pready}, 32'h0);
    chk("idle_state",  {29'h0, fsm_state}, 32'h0);
    chk("ena_count",   ena_cnt - c0, v.legal ? 32'd1 : 32'd0);
  endtask

  initial begin
    //          wr    addr      wdata         strb   rdata         err   legal exp_addr  exp_prdata    exp_err
    vecs[0] = '{1'b0, 15'h0004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 13'h0001, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 15'h7FFC, 32'h12345678, 4'hF, 32'h55555555, 1'b0, 1'b1, 13'h1FFF, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 15'h0010, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1, 1'b1, 13'h0004, 32'hCAFEF00D, 1'b1};
    vecs[3] = '{1'b1, 15'h0002, 32'hAAAA0001, 4'hF, 32'h0,        1'b0, 1'b0, 13'h0,    32'h0,        1'b1};
    vecs[4] = '{1'b1, 15'h0008, 32'hAAAA0002, 4'h3, 32'h0,        1'b0, 1'b0, 13'h0,    32'h0,        1'b1};
    vecs[5] = '{1'b0, 15'h0006, 32'h0,        4'hF, 32'h0,        1'b0, 1'b0, 13'h0,    32'h0,        1'b1};
    vecs[6] = '{1'b0, 15'h0100, 32'h0,        4'h0, 32'hA5A55A5A, 1'b0, 1'b1, 13'h0040, 32'hA5A55A5A, 1'b0};
    vecs[7] = '{1'b1, 15'h0020, 32'h0F0F0F0F, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 13'h0008, 32'h0,        1'b1};

    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) do_xfer(vecs[i]);

    // reset asserted in CAP of a read: outputs drop at once, no pready
    @(negedge clk);
    drive_setup(vecs[0]);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("rst_seq_in_cap", {29'h0, fsm_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    bus_idle();
    @(negedge clk);
    chk("rst_no_pready", {31'h0, pready}, 32'h0);
    rst_n = 1'b1;
    do_xfer(vecs[0]);

    // psel dropped during CAP: access still completes with one strobe
    begin
      int c0;
      @(negedge clk);
      drive_setup(vecs[6]);
      c0 = ena_cnt;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      mem_rdata = 32'h11112222; mem_err = 1'b0;
      @(negedge clk);
      chk("drop_pready", {31'h0, pready}, 32'h1);
      chk("drop_prdata", prdata, 32'h11112222);
      chk("drop_pslverr", {31'h0, pslverr}, 32'h0);
      bus_idle();
      @(negedge clk);
      chk("drop_state", {29'h0, fsm_state}, 32'h0);
      chk("drop_ena_count", ena_cnt - c0, 32'd1);
    end
    do_xfer(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
